// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin select controller of the 8:1 mux.
//   state_e   : controller state encoding
//   MUX_N     : default number of requesters / mux inputs
//   MUX_SEL_W : default select width ($clog2(MUX_N))
package mux_arb_pkg;

  localparam int MUX_N     = 8;
  localparam int MUX_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
//   req [N]     : request vector
//   ptr [SEL_W] : index with highest priority this round
//   any         : at least one request set
//   idx [SEL_W] : first set request scanning ptr, ptr+1, ... mod N
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Rotating the doubled vector puts req[ptr] at bit 0, so the lowest set
  // bit of rot is the offset of the winner from ptr.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |req;
  // N is a power of two, so the SEL_W-bit add wraps mod N for free.
  assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin grant controller driving the select input of mux_8to1.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req [N]     : level requests, held until granted
//   rel [N]     : release pulses, only the owner's bit is honoured in GRANT
//   gnt [N]     : registered one-hot grant, zero when nobody owns the mux
//   sel [SEL_W] : owner index, holds the last owner while idle
//   sel_valid   : high while a grant is active
//   timeout     : one-cycle pulse on a forced release
// Build option: define MUX_ARB_TIMEOUT_EN to add the hold counter that forces
// a release after HOLD_MAX grant cycles when another requester is waiting.
// Without it timeout is tied low and a grant is held until released.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner; arbitrate any pending request
// ST_GRANT | owner holds gnt/sel until release (or forced release)
// ST_GAP   | one bubble cycle for the mux to settle before re-arbitration
module mux_rr_sel_ctrl
  import mux_arb_pkg::*;
#(
  parameter int N        = MUX_N,
  parameter int SEL_W    = $clog2(N),
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     rel,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             own_rel;
  logic             force_rel;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // sel_q is the owner index while in GRANT; dropping the request counts as release.
  assign own_rel = rel[sel_q] | ~req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  // Cleared while idle so it starts at zero on GRANT entry; saturates at the
  // terminal value so a competitor arriving late still triggers the release.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_IDLE) begin
      hold_d = '0;
    end else if (state_q == ST_GRANT && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 8'd1;
    end
  end

  assign force_rel = (state_q == ST_GRANT) && (hold_q == HOLD_LAST) && (|(req & ~gnt_q));
`else
  // HOLD_MAX only matters in the timeout build.
  logic unused_hold_max;
  assign unused_hold_max = ^HOLD_MAX;
  assign force_rel       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_GRANT;
      ST_GRANT: if (own_rel || force_rel) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d = N'(1) << pick_idx;
          sel_d = pick_idx;
          ptr_d = pick_idx + SEL_W'(1);
        end
      end
      ST_GRANT: begin
        if (own_rel || force_rel) begin
          gnt_d     = '0;
          timeout_d = force_rel & ~own_rel;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = (state_q == ST_GRANT);
  assign timeout   = timeout_q;

endmodule
